// File: rtl/writeback_regfile_p_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile_p_if
// Description : Writeback bus bundle between the pipeline and the
//               writeback/register-file stage. Carries the candidate
//               write results, register indices and the registered
//               operand/condition-code returns.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_regfile_p_if #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
);
    logic                      enable_writeback;
    logic [DATA_WIDTH-1:0]     aluout;
    logic [DATA_WIDTH-1:0]     memout;
    logic [DATA_WIDTH-1:0]     pcout;
    logic [DATA_WIDTH-1:0]     npc;
    logic [1:0]                W_Control;
    logic [REG_ADDR_WIDTH-1:0] dr;
    logic [REG_ADDR_WIDTH-1:0] sr1;
    logic [REG_ADDR_WIDTH-1:0] sr2;
    logic [DATA_WIDTH-1:0]     VSR1;
    logic [DATA_WIDTH-1:0]     VSR2;
    logic [2:0]                psr;

    // Pipeline side: drives results and indices, receives operands.
    modport master (
        output enable_writeback, aluout, memout, pcout, npc,
        output W_Control, dr, sr1, sr2,
        input  VSR1, VSR2, psr
    );

    // Writeback stage side.
    modport slave (
        input  enable_writeback, aluout, memout, pcout, npc,
        input  W_Control, dr, sr1, sr2,
        output VSR1, VSR2, psr
    );
endinterface
`default_nettype wire

// File: rtl/writeback_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : writeback_regfile_p
// Description : Parametrised LC-3-class writeback stage with integrated
//               register file. Selects one of four results, writes it to
//               register dr, updates the {N,Z,P} condition codes and
//               returns registered operands for sr1/sr2 every cycle.
//               Optional macro WRITEBACK_BYPASS_EN forwards a same-cycle
//               write into the operand registers.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_regfile_p #(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  wire                   clock,
    input  wire                   reset,
    writeback_regfile_p_if.slave  bus
);

    localparam int c_NUM_REGS = 1 << REG_ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] r_regs [c_NUM_REGS];
    logic [DATA_WIDTH-1:0] r_vsr1;
    logic [DATA_WIDTH-1:0] r_vsr2;
    logic [2:0]            r_psr;

    logic [DATA_WIDTH-1:0] w_wdata;
    logic [2:0]            w_psr_next;
    logic [DATA_WIDTH-1:0] w_rd1;
    logic [DATA_WIDTH-1:0] w_rd2;

    // Select the result to be written back.
    always_comb begin
        w_wdata = bus.aluout;
        case (bus.W_Control)
            2'd0:    w_wdata = bus.aluout;
            2'd1:    w_wdata = bus.memout;
            2'd2:    w_wdata = bus.pcout;
            default: w_wdata = bus.npc;
        endcase
    end

    // Classify the write data into exactly one of N, Z, P.
    always_comb begin
        w_psr_next = 3'b001;
        if (w_wdata[DATA_WIDTH-1]) begin
            w_psr_next = 3'b100;
        end else if (w_wdata == '0) begin
            w_psr_next = 3'b010;
        end
    end

    // Operand read data; with bypass a same-cycle write to the read index wins.
    always_comb begin
        w_rd1 = r_regs[bus.sr1];
        w_rd2 = r_regs[bus.sr2];
`ifdef WRITEBACK_BYPASS_EN
        if (bus.enable_writeback && (bus.sr1 == bus.dr)) begin
            w_rd1 = w_wdata;
        end
        if (bus.enable_writeback && (bus.sr2 == bus.dr)) begin
            w_rd2 = w_wdata;
        end
`endif
    end

    // Register file write, condition codes and registered operand reads.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < c_NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_vsr1 <= '0;
            r_vsr2 <= '0;
            r_psr  <= 3'b000;
        end else begin
            if (bus.enable_writeback) begin
                r_regs[bus.dr] <= w_wdata;
                r_psr          <= w_psr_next;
            end
            r_vsr1 <= w_rd1;
            r_vsr2 <= w_rd2;
        end
    end

    assign bus.VSR1 = r_vsr1;
    assign bus.VSR2 = r_vsr2;
    assign bus.psr  = r_psr;

endmodule
`default_nettype wire

// File: tb/tb_writeback_regfile_p.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_regfile_p
// Description : Self-checking bench for writeback_regfile_p. A behavioural
//               register-file model predicts VSR1/VSR2/psr every cycle;
//               directed literal checks pin the model; a second instance
//               covers the 32-bit, 16-register configuration.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_regfile_p;

    logic clock = 1'b0;
    logic reset = 1'b1;

    always #5 clock = ~clock;

    writeback_regfile_p_if #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) bus_a ();
    writeback_regfile_p_if #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) bus_b ();

    writeback_regfile_p #(.DATA_WIDTH(16), .REG_ADDR_WIDTH(3)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    writeback_regfile_p #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    // Reference model of the 16-bit instance.
    logic [15:0] m_regs [8];
    logic [15:0] exp_v1, exp_v2;
    logic [2:0]  exp_psr;

    function automatic logic [15:0] pick(input logic [1:0] sel, input logic [15:0] a,
                                         input logic [15:0] m, input logic [15:0] p,
                                         input logic [15:0] n);
        logic [15:0] vals [4];
        vals[0] = a; vals[1] = m; vals[2] = p; vals[3] = n;
        return vals[sel];
    endfunction

    function automatic logic [2:0] cc(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0)     return 3'b010;
        return 3'b001;
    endfunction

    always @(posedge clock) begin
        logic [15:0] wd, v1, v2;
        if (reset) begin
            for (int i = 0; i < 8; i++) m_regs[i] = 16'd0;
            exp_v1  = 16'd0;
            exp_v2  = 16'd0;
            exp_psr = 3'b000;
        end else begin
            wd = pick(bus_a.W_Control, bus_a.aluout, bus_a.memout, bus_a.pcout, bus_a.npc);
            v1 = m_regs[bus_a.sr1];
            v2 = m_regs[bus_a.sr2];
`ifdef WRITEBACK_BYPASS_EN
            if (bus_a.enable_writeback && bus_a.sr1 == bus_a.dr) v1 = wd;
            if (bus_a.enable_writeback && bus_a.sr2 == bus_a.dr) v2 = wd;
`endif
            if (bus_a.enable_writeback) begin
                m_regs[bus_a.dr] = wd;
                exp_psr = cc(wd);
            end
            exp_v1 = v1;
            exp_v2 = v2;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // One clock cycle, then compare the DUT against the model away from the edge.
    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        if (check_en) begin
            chk("model_vsr1", {16'd0, bus_a.VSR1}, {16'd0, exp_v1});
            chk("model_vsr2", {16'd0, bus_a.VSR2}, {16'd0, exp_v2});
            chk("model_psr",  {29'd0, bus_a.psr},  {29'd0, exp_psr});
        end
    endtask

    task automatic wr_a(input logic [2:0] d, input logic [1:0] sel, input logic [15:0] v);
        bus_a.enable_writeback = 1'b1;
        bus_a.dr        = d;
        bus_a.W_Control = sel;
        bus_a.aluout    = v;
        bus_a.memout    = v;
        bus_a.pcout     = v;
        bus_a.npc       = v;
    endtask

    initial begin
        logic [15:0] exp_rd [4];
        logic [2:0]  exp_cc [4];
        logic [15:0] bypass_exp;

        bus_a.enable_writeback = 1'b1;
        bus_a.aluout = 16'h1234; bus_a.memout = 16'h0; bus_a.pcout = 16'h0; bus_a.npc = 16'h0;
        bus_a.W_Control = 2'd0; bus_a.dr = 3'd3; bus_a.sr1 = 3'd3; bus_a.sr2 = 3'd0;
        bus_b.enable_writeback = 1'b0;
        bus_b.aluout = 32'h0; bus_b.memout = 32'h0; bus_b.pcout = 32'h0; bus_b.npc = 32'h0;
        bus_b.W_Control = 2'd0; bus_b.dr = 4'd0; bus_b.sr1 = 4'd0; bus_b.sr2 = 4'd0;

        // Reset dominates a write presented in the same cycle.
        tick();
        check_en = 1'b1;
        tick();
        reset = 1'b0;
        bus_a.enable_writeback = 1'b0;
        tick();
        chk("reset_r3", {16'd0, bus_a.VSR1}, 32'h0);
        chk("reset_psr", {29'd0, bus_a.psr}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus_a.sr1 = 3'(i);
            bus_a.sr2 = 3'(7 - i);
            tick();
            chk("reset_read", {16'd0, bus_a.VSR1 | bus_a.VSR2}, 32'h0);
        end

        // All four write-data sources into R1..R4.
        exp_cc[0] = 3'b001; exp_cc[1] = 3'b100; exp_cc[2] = 3'b010; exp_cc[3] = 3'b001;
        exp_rd[0] = 16'h0001; exp_rd[1] = 16'h8000; exp_rd[2] = 16'h0000; exp_rd[3] = 16'h3001;
        bus_a.aluout = 16'h0001; bus_a.memout = 16'h8000; bus_a.pcout = 16'h0000; bus_a.npc = 16'h3001;
        for (int i = 0; i < 4; i++) begin
            bus_a.enable_writeback = 1'b1;
            bus_a.W_Control = 2'(i);
            bus_a.dr = 3'(i + 1);
            tick();
            chk("mux_psr", {29'd0, bus_a.psr}, {29'd0, exp_cc[i]});
        end
        bus_a.enable_writeback = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bus_a.sr1 = 3'(i + 1);
            tick();
            chk("mux_read", {16'd0, bus_a.VSR1}, {16'd0, exp_rd[i]});
        end

        // psr holds while writes are idle.
        wr_a(3'd5, 2'd0, 16'hBEEF);
        bus_a.sr1 = 3'd5; bus_a.sr2 = 3'd5;
        tick();
        bus_a.enable_writeback = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("hold_psr", {29'd0, bus_a.psr}, 32'h4);
            chk("hold_vsr1", {16'd0, bus_a.VSR1}, 32'hBEEF);
            chk("hold_vsr2", {16'd0, bus_a.VSR2}, 32'hBEEF);
        end

        // Same-cycle write and read of R2.
        wr_a(3'd2, 2'd1, 16'h0011);
        bus_a.sr1 = 3'd0;
        tick();
        wr_a(3'd2, 2'd2, 16'h00AA);
        bus_a.sr1 = 3'd2;
        tick();
`ifdef WRITEBACK_BYPASS_EN
        bypass_exp = 16'h00AA;
`else
        bypass_exp = 16'h0011;
`endif
        chk("same_cycle_vsr1", {16'd0, bus_a.VSR1}, {16'd0, bypass_exp});
        bus_a.enable_writeback = 1'b0;
        tick();
        chk("after_write_vsr1", {16'd0, bus_a.VSR1}, 32'h00AA);

        // Back-to-back writes to R7: last one wins.
        wr_a(3'd7, 2'd3, 16'h0005);
        bus_a.sr1 = 3'd0;
        tick();
        wr_a(3'd7, 2'd0, 16'hFFFF);
        tick();
        bus_a.enable_writeback = 1'b0;
        bus_a.sr1 = 3'd7;
        tick();
        chk("b2b_vsr1", {16'd0, bus_a.VSR1}, 32'hFFFF);
        chk("b2b_psr", {29'd0, bus_a.psr}, 32'h4);

        // Wide configuration: 32-bit data, 16 registers.
        bus_b.enable_writeback = 1'b1;
        bus_b.W_Control = 2'd0;
        bus_b.dr = 4'd15;
        bus_b.aluout = 32'h8000_0000;
        tick();
        bus_b.enable_writeback = 1'b0;
        bus_b.sr1 = 4'd15;
        bus_b.sr2 = 4'd0;
        tick();
        chk("wide_r15", bus_b.VSR1, 32'h8000_0000);
        chk("wide_psr", {29'd0, bus_b.psr}, 32'h4);
        for (int i = 0; i < 15; i++) begin
            bus_b.sr1 = 4'(i);
            bus_b.sr2 = 4'(14 - i);
            tick();
            chk("wide_zero", bus_b.VSR1 | bus_b.VSR2, 32'h0);
        end

        // Randomised traffic with occasional mid-stream reset.
        for (int n = 0; n < 400; n++) begin
            logic [15:0] v;
            case ($urandom_range(0, 3))
                0:       v = 16'h0000;
                1:       v = 16'h8000 | 16'($urandom);
                default: v = 16'($urandom);
            endcase
            reset = ($urandom_range(0, 39) == 0);
            bus_a.enable_writeback = 1'($urandom);
            bus_a.W_Control = 2'($urandom);
            bus_a.aluout = v;
            bus_a.memout = 16'($urandom);
            bus_a.pcout  = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            bus_a.npc    = 16'($urandom);
            bus_a.dr  = 3'($urandom);
            bus_a.sr1 = ($urandom_range(0, 2) == 0) ? bus_a.dr : 3'($urandom);
            bus_a.sr2 = ($urandom_range(0, 3) == 0) ? bus_a.sr1 : 3'($urandom);
            tick();
        end
        reset = 1'b0;
        bus_a.enable_writeback = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
